// File: rtl/acc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// acc_seq_ctrl
//
// Program sequencer for the 4-bit accumulator datapath.
//
// A small instruction store (2**ADDR_W bytes) is written over the prog_* port
// while the sequencer is not running. A start pulse launches a
// fetch / decode / issue loop from pc = 0:
//   - NOP, JMP, JZ, JC and HLT are resolved locally in DECODE.
//   - ALU opcodes 0x1..0xB are handed to the datapath over op_valid/op_ready.
//
// Instruction word: [7:4] opcode, [3:0] immediate.
//
// Handshake: op_valid is high for every cycle the FSM sits in ISSUE.
// op_code/op_imm are stable while op_valid is high. A transfer happens on a
// rising clk edge where op_valid and op_ready are both high. op_valid drops on
// the following cycle. It also drops on a timeout, on stop and on rst.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   prog_we/addr/  store write port (honoured only in IDLE/HALT/ERROR)
//   prog_data
//   start          1-cycle pulse: pc <= 0, retired <= 0, run
//   stop           abort to IDLE (wins over start)
//   acc_zero/carry datapath flags, sampled in DECODE by JZ/JC
//   op_ready       datapath accepts the issued op this cycle
//   op_valid/code/ op issue request and its payload
//   op_imm
//   pc             current program counter
//   busy/halted/   state-decoded status (FETCH|DECODE|ISSUE / HALT / ERROR)
//   error
//   retired        retired-instruction count, saturating at 255
// -----------------------------------------------------------------------------
module acc_seq_ctrl #(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [7:0]        prog_data,
  input  logic              start,
  input  logic              stop,
  input  logic              acc_zero,
  input  logic              acc_carry,
  input  logic              op_ready,
  output logic              op_valid,
  output logic [3:0]        op_code,
  output logic [3:0]        op_imm,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              error,
  output logic [7:0]        retired
);

  localparam int DEPTH = 2 ** ADDR_W;

  // The wait counter only has to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_JZ  = 4'hD;
  localparam logic [3:0] OP_JC  = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_ISSUE  = 3'd3,
    S_HALT   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [7:0]        r_ir;
  logic [7:0]        r_retired;
  logic [CNT_W-1:0]  r_wait;
  logic [7:0]        r_store [DEPTH];

  // ---------------------------------------------------------------------------
  // Next-state wires
  // ---------------------------------------------------------------------------
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [7:0]        w_ir_nxt;
  logic [CNT_W-1:0]  w_wait_nxt;
  logic              w_retire;
  logic              w_clr_retired;
  logic              w_store_we;
  logic [7:0]        w_retired_nxt;

  logic [3:0]        w_opc;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_target;
  logic              w_forwarded;

  assign w_opc       = r_ir[7:4];
  // PC arithmetic wraps naturally at ADDR_W bits.
  assign w_pc_inc    = r_pc + 1'b1;
  // Branch target: immediate truncated or zero-extended to the pc width.
  assign w_target    = ADDR_W'(r_ir[3:0]);
  assign w_forwarded = (w_opc != OP_NOP) && (w_opc < OP_JMP);

  // ---------------------------------------------------------------------------
  // FSM: next state and datapath controls
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_ir_nxt      = r_ir;
    w_wait_nxt    = r_wait;
    w_retire      = 1'b0;
    w_clr_retired = 1'b0;
    w_store_we    = 1'b0;

    unique case (r_state)
      S_IDLE, S_HALT, S_ERROR: begin
        // Store is writable whenever the sequencer is parked. A write and a
        // start in the same cycle both take effect; the fetch that follows
        // already sees the new word.
        w_store_we = prog_we;
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else if (start) begin
          w_state_nxt   = S_FETCH;
          w_pc_nxt      = '0;
          w_clr_retired = 1'b1;
        end
      end

      S_FETCH: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_ir_nxt    = r_store[r_pc];
          w_state_nxt = S_DECODE;
        end
      end

      S_DECODE: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else if (w_forwarded) begin
          w_wait_nxt  = '0;
          w_state_nxt = S_ISSUE;
        end else begin
          w_retire = 1'b1;
          unique case (w_opc)
            OP_HLT: begin
              w_state_nxt = S_HALT;
            end
            OP_JMP: begin
              w_pc_nxt    = w_target;
              w_state_nxt = S_FETCH;
            end
            OP_JZ: begin
              w_pc_nxt    = acc_zero ? w_target : w_pc_inc;
              w_state_nxt = S_FETCH;
            end
            OP_JC: begin
              w_pc_nxt    = acc_carry ? w_target : w_pc_inc;
              w_state_nxt = S_FETCH;
            end
            default: begin
              // NOP
              w_pc_nxt    = w_pc_inc;
              w_state_nxt = S_FETCH;
            end
          endcase
        end
      end

      S_ISSUE: begin
        // stop wins over a coincident handshake: the op is not retired.
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else if (op_ready) begin
          w_pc_nxt    = w_pc_inc;
          w_retire    = 1'b1;
          w_state_nxt = S_FETCH;
        end else if ((TIMEOUT != 0) && (r_wait == WAIT_LAST)) begin
          // op_valid has now been up for TIMEOUT cycles without op_ready.
          w_state_nxt = S_ERROR;
        end else if (TIMEOUT != 0) begin
          w_wait_nxt = r_wait + 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Retired count: cleared on start, saturates at 255.
  always_comb begin
    w_retired_nxt = r_retired;
    if (w_clr_retired) begin
      w_retired_nxt = '0;
    end else if (w_retire && (r_retired != 8'hFF)) begin
      w_retired_nxt = r_retired + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_ir      <= '0;
      r_retired <= '0;
      r_wait    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_ir      <= w_ir_nxt;
      r_retired <= w_retired_nxt;
      r_wait    <= w_wait_nxt;
    end
  end

  // Instruction store: contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && w_store_we) begin
      r_store[prog_addr] <= prog_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state only
  // ---------------------------------------------------------------------------
  assign op_valid = (r_state == S_ISSUE);
  assign op_code  = op_valid ? r_ir[7:4] : 4'h0;
  assign op_imm   = op_valid ? r_ir[3:0] : 4'h0;
  assign pc       = r_pc;
  assign busy     = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_ISSUE);
  assign halted   = (r_state == S_HALT);
  assign error    = (r_state == S_ERROR);
  assign retired  = r_retired;

endmodule

// File: doc/acc_seq_ctrl.md
Name: acc_seq_ctrl

Overview:
Program sequencer for the 4-bit accumulator datapath. Holds a 16-entry instruction store, loaded over a write port while idle. On start it runs a fetch/decode/issue FSM. Branch, NOP and halt instructions resolve locally; ALU instructions go to the accumulator over a valid/ready handshake.

Parameters:
ADDR_W, 4, program-counter and store address width (store depth = 2**ADDR_W)
TIMEOUT, 15, max cycles op_valid may wait for op_ready before error (0 disables)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
prog_we  input  1  store write strobe; honoured only in IDLE/HALT/ERROR
prog_addr  input  ADDR_W  store write address
prog_data  input  8  instruction word: [7:4] opcode, [3:0] immediate
start  input  1  1-cycle pulse: pc<=0, begin execution
stop  input  1  abort; return to IDLE
acc_zero  input  1  datapath accumulator==0 flag
acc_carry  input  1  datapath carry flag
op_ready  input  1  datapath accepts op this cycle
op_valid  output  1  op issue request
op_code  output  4  opcode to datapath
op_imm  output  4  immediate to datapath
pc  output  ADDR_W  current program counter
busy  output  1  in FETCH/DECODE/ISSUE
halted  output  1  in HALT
error  output  1  in ERROR
retired  output  8  retired-instruction count, saturating at 255

Behaviour:
- Reset: state IDLE, pc=0, ir=0, retired=0; op_valid, busy, halted, error = 0; op_code/op_imm = 0. Store contents are not reset.
- Opcodes:
  - 0x0 NOP: local
  - 0x1-0xB: forwarded (LDI, ADD, SUB, AND, OR, XOR, NOT, SHL, SHR, 0xA/0xB spare)
  - 0xC JMP: pc<=imm
  - 0xD JZ: pc<=imm if acc_zero, else pc+1
  - 0xE JC: pc<=imm if acc_carry, else pc+1
  - 0xF HLT
- States: IDLE, FETCH, DECODE, ISSUE, HALT, ERROR.
- IDLE: start -> FETCH with pc=0, retired=0. prog_we writes store[prog_addr] in the same edge. start and prog_we in the same cycle: write happens, then start proceeds.
- FETCH (1 cycle): ir<=store[pc] -> DECODE.
- DECODE (1 cycle):
  - local op: pc updated, retired+1, -> FETCH. Local ops therefore take 2 cycles.
  - HLT: pc unchanged, retired+1, -> HALT.
  - forwarded op: -> ISSUE.
  - acc_zero/acc_carry are sampled in DECODE.
- ISSUE: op_valid=1, op_code/op_imm driven from ir and held stable until handshake.
  - Handshake: op_valid&op_ready at a clock edge -> pc<=pc+1, retired+1, -> FETCH.
  - Minimum forwarded-op time is 3 cycles.
  - op_valid drops the cycle after handshake.
- Timeout: wait counter clears on entering ISSUE. If op_ready is not seen within TIMEOUT cycles -> ERROR, op_valid drops.
- PC arithmetic is modulo 2**ADDR_W: pc=15 with +1 wraps to 0. Branch targets are imm truncated/zero-extended to ADDR_W.
- HALT and ERROR: sticky. start restarts from pc=0 (clears error/halted); stop -> IDLE. Outputs halted/error are state-decoded (registered state, no input paths).
- stop:
  - In any running state, -> IDLE on next edge; op_valid deasserts immediately on that edge. A handshake coincident with stop is not retired.
  - stop has priority over start; both asserted -> IDLE.
- start while busy: ignored.
- prog_we while busy: ignored (store unchanged).
- retired saturates at 255 and does not wrap.
- Synchronous rst mid-operation: returns to reset values on the next edge regardless of handshake in progress.

Test Plan:
- Load [0]=0x21 (ADD 1), [1]=0x31 (SUB 1), [2]=0xF0; start, op_ready tied 1 -> op issues (0x2,0x1) then (0x3,0x1); HALT with pc=2, retired=3; total 8 cycles from start to halted.
- Load [0]=0xC5, [5]=0xF0; start -> no op_valid ever; halted with pc=5, retired=2.
- JZ taken/not-taken: [0]=0xD7, acc_zero=1 -> pc=7; rerun with acc_zero=0 -> pc=1. Repeat for JC with acc_carry.
- Backpressure: [0]=0x12, op_ready low 5 cycles -> op_valid held with op_code=0x1, op_imm=0x2 stable; ready -> single retire. With TIMEOUT=15 and ready held low 16 cycles -> error=1, op_valid=0.
- Wrap: store all 0x00 except [15]=0x00 (all NOP), stop after 40 cycles -> pc visited 15->0, retired=20 at stop; prog_we attempted during run leaves store unchanged (readback via later run).
- Abort/reset: stop during ISSUE with op_ready asserted same cycle -> IDLE, retired not incremented. rst mid-run -> all outputs at reset values next cycle.
